// File: rtl/rams_arb_pkg.sv
// Shared types and helpers for the round-robin single-port RAM controller.
package rams_arb_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_ARB  = 1'b1
    } state_t;

    // Pointer advance past the granted requester, wrapping at n.
    function automatic int ptr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rams_sp_arb_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int PW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [PW-1:0]   grant_idx,
    output logic            any_grant
);

    int w_pos;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        w_pos     = 0;
        for (int k = 0; k < NREQ; k++) begin
            w_pos = int'(ptr) + k;
            if (w_pos >= NREQ) w_pos = w_pos - NREQ;
            for (int i = 0; i < NREQ; i++) begin
                if (!any_grant && req[i] && (i == w_pos)) begin
                    any_grant = 1'b1;
                    grant[i]  = 1'b1;
                    grant_idx = PW'(i);
                end
            end
        end
    end

endmodule

// File: rtl/rams_sp_arb.sv
// Shares one write-first single-port RAM among NREQ requesters, round-robin,
// with an optional zero-fill pass after reset.
module rams_sp_arb
    import rams_arb_pkg::*;
#(
    parameter int NREQ       = 4,
    parameter int AW         = 10,
    parameter int DW         = 16,
    parameter bit INIT_CLEAR = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ-1:0]    req_we,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]    rsp_valid,
    output logic [DW-1:0]      rsp_data,
    output logic               init_done,
    output logic               ram_en,
    output logic               ram_we,
    output logic [AW-1:0]      ram_addr,
    output logic [DW-1:0]      ram_di,
    input  logic [DW-1:0]      ram_dout
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [AW-1:0]   r_clr_cnt;
    logic [PW-1:0]   r_ptr;
    logic [NREQ-1:0] r_rsp_valid;

    logic [NREQ-1:0] w_grant;
    logic [PW-1:0]   w_gidx;
    logic            w_any;
    logic            w_gwe;
    logic [AW-1:0]   w_gaddr;
    logic [DW-1:0]   w_gdata;

    rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (
        .req       (req_valid),
        .ptr       (r_ptr),
        .grant     (w_grant),
        .grant_idx (w_gidx),
        .any_grant (w_any)
    );

    // One-hot grant makes an OR-mux sufficient; no grant yields all zeros.
    always_comb begin
        w_gwe   = 1'b0;
        w_gaddr = '0;
        w_gdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                w_gwe   = w_gwe   | req_we[i];
                w_gaddr = w_gaddr | req_addr[i*AW +: AW];
                w_gdata = w_gdata | req_wdata[i*DW +: DW];
            end
        end
    end

    // Outputs are gated by rst_n so the RAM and clients see idle during reset.
    always_comb begin
        w_state_nxt = r_state;
        req_ready   = '0;
        ram_en      = 1'b0;
        ram_we      = 1'b0;
        ram_addr    = '0;
        ram_di      = '0;
        if (rst_n) begin
            case (r_state)
                ST_INIT: begin
                    ram_en   = 1'b1;
                    ram_we   = 1'b1;
                    ram_addr = r_clr_cnt;
                    if (r_clr_cnt == {AW{1'b1}}) w_state_nxt = ST_ARB;
                end
                ST_ARB: begin
                    req_ready = w_grant;
                    ram_en    = w_any;
                    ram_we    = w_gwe;
                    ram_addr  = w_gaddr;
                    ram_di    = w_gdata;
                end
                default: w_state_nxt = ST_ARB;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= INIT_CLEAR ? ST_INIT : ST_ARB;
            r_clr_cnt   <= '0;
            r_ptr       <= '0;
            r_rsp_valid <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_INIT) r_clr_cnt <= r_clr_cnt + AW'(1);
            r_rsp_valid <= (r_state == ST_ARB) ? w_grant : '0;
            if ((r_state == ST_ARB) && w_any)
                r_ptr <= PW'(ptr_next(int'(w_gidx), NREQ));
        end
    end

    assign init_done = (r_state == ST_ARB);
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = ram_dout;

endmodule

// File: tb/tb_rams_sp_arb.sv
// Randomized bench for rams_sp_arb against a behavioural arbitration/memory model.
module tb_rams_sp_arb;

    localparam int NREQ  = 4;
    localparam int AW    = 10;
    localparam int DW    = 16;
    localparam int DEPTH = 1 << AW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, rst0_n;

    logic [NREQ-1:0]    v, we, rdy, rv;
    logic [NREQ*AW-1:0] addr;
    logic [NREQ*DW-1:0] wd;
    logic [DW-1:0]      rd, rdi, rdout;
    logic               idone, ren, rwe;
    logic [AW-1:0]      raddr;

    logic [NREQ-1:0]    v0, we0, rdy0, rv0;
    logic [NREQ*AW-1:0] addr0;
    logic [NREQ*DW-1:0] wd0;
    logic [DW-1:0]      rd0, rdi0, rdout0;
    logic               idone0, ren0, rwe0;
    logic [AW-1:0]      raddr0;

    rams_sp_arb #(.NREQ(NREQ), .AW(AW), .DW(DW), .INIT_CLEAR(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(v), .req_ready(rdy), .req_we(we),
        .req_addr(addr), .req_wdata(wd), .rsp_valid(rv), .rsp_data(rd),
        .init_done(idone), .ram_en(ren), .ram_we(rwe), .ram_addr(raddr),
        .ram_di(rdi), .ram_dout(rdout)
    );

    rams_sp_arb #(.NREQ(NREQ), .AW(AW), .DW(DW), .INIT_CLEAR(1'b0)) dut0 (
        .clk(clk), .rst_n(rst0_n), .req_valid(v0), .req_ready(rdy0), .req_we(we0),
        .req_addr(addr0), .req_wdata(wd0), .rsp_valid(rv0), .rsp_data(rd0),
        .init_done(idone0), .ram_en(ren0), .ram_we(rwe0), .ram_addr(raddr0),
        .ram_di(rdi0), .ram_dout(rdout0)
    );

    // External write-first RAMs, one per DUT.
    logic [DW-1:0] mem1 [DEPTH];
    logic [DW-1:0] mem0 [DEPTH];

    always @(posedge clk) begin
        if (ren) begin
            if (rwe) begin mem1[raddr] <= rdi; rdout <= rdi; end
            else rdout <= mem1[raddr];
        end
        if (ren0) begin
            if (rwe0) begin mem0[raddr0] <= rdi0; rdout0 <= rdi0; end
            else rdout0 <= mem0[raddr0];
        end
    end

    logic [DW-1:0] ref_mem [DEPTH];
    int            ptr_m;
    int            exp_gnt;
    logic [DW-1:0] exp_data;
    int            checks = 0;
    int            errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive_rand(input int amax);
        v  = NREQ'($urandom);
        we = NREQ'($urandom);
        for (int i = 0; i < NREQ; i++) begin
            addr[i*AW +: AW] = AW'($urandom_range(0, amax));
            wd[i*DW +: DW]   = DW'($urandom);
        end
    endtask

    // Called just after inputs are driven at a negedge; returns at the next negedge.
    task automatic arb_cycle();
        int g, bd, d;
        logic [AW-1:0] a;
        #1;
        g  = -1;
        bd = NREQ;
        for (int i = 0; i < NREQ; i++) begin
            if (v[i]) begin
                d = (i - ptr_m + NREQ) % NREQ;
                if (d < bd) begin bd = d; g = i; end
            end
        end
        chk("req_ready", 32'(rdy), (g < 0) ? 32'd0 : (32'd1 << g));
        chk("ram_en", 32'(ren), (g >= 0) ? 32'd1 : 32'd0);
        if (g >= 0) begin
            a = addr[g*AW +: AW];
            chk("ram_we", 32'(rwe), 32'(we[g]));
            chk("ram_addr", 32'(raddr), 32'(a));
            if (we[g]) begin
                chk("ram_di", 32'(rdi), 32'(wd[g*DW +: DW]));
                ref_mem[a] = wd[g*DW +: DW];
            end
            exp_data = ref_mem[a];
            ptr_m    = (g + 1) % NREQ;
        end
        exp_gnt = g;
        @(posedge clk);
        @(negedge clk);
        chk("rsp_valid", 32'(rv), (exp_gnt < 0) ? 32'd0 : (32'd1 << exp_gnt));
        if (exp_gnt >= 0) chk("rsp_data", 32'(rd), 32'(exp_data));
    endtask

    // Clearing pass: n cycles starting at a negedge with rst_n already high.
    task automatic init_run(input int n, input bit full);
        for (int c = 0; c < n; c++) begin
            drive_rand(DEPTH - 1);
            #1;
            chk("init_en", 32'(ren), 32'd1);
            chk("init_we", 32'(rwe), 32'd1);
            chk("init_di", 32'(rdi), 32'd0);
            chk("init_addr", 32'(raddr), 32'(c));
            chk("init_ready", 32'(rdy), 32'd0);
            chk("init_rsp", 32'(rv), 32'd0);
            chk("init_done_lo", 32'(idone), 32'd0);
            @(posedge clk);
            @(negedge clk);
        end
        if (full) begin
            v = '0;
            #1;
            chk("init_done_hi", 32'(idone), 32'd1);
            for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
            ptr_m = 0;
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem1[i] = DW'($urandom);
            mem0[i] = DW'($urandom);
        end
        rst_n = 1'b0; rst0_n = 1'b0;
        v = '1; we = '1; addr = '0; wd = '1;
        v0 = '1; we0 = '0; addr0 = '0; wd0 = '0;
        ptr_m = 0; exp_gnt = -1; exp_data = '0;

        repeat (3) @(negedge clk);
        #1;
        chk("rst_ready", 32'(rdy), 32'd0);
        chk("rst_en", 32'(ren), 32'd0);
        chk("rst_we", 32'(rwe), 32'd0);
        chk("rst_rsp", 32'(rv), 32'd0);
        chk("rst_done", 32'(idone), 32'd0);
        chk("rst0_done", 32'(idone0), 32'd1);
        chk("rst0_ready", 32'(rdy0), 32'd0);
        chk("rst0_en", 32'(ren0), 32'd0);

        // Interrupt clearing at address 500, then a full clean pass.
        @(negedge clk);
        rst_n = 1'b1;
        init_run(500, 1'b0);
        #1;
        chk("mid_init_addr", 32'(raddr), 32'd500);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mrst_en", 32'(ren), 32'd0);
        chk("mrst_we", 32'(rwe), 32'd0);
        chk("mrst_addr", 32'(raddr), 32'd0);
        chk("mrst_di", 32'(rdi), 32'd0);
        chk("mrst_ready", 32'(rdy), 32'd0);
        chk("mrst_rsp", 32'(rv), 32'd0);
        chk("mrst_done", 32'(idone), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        init_run(DEPTH, 1'b1);

        v = 4'b0001; we = '0; addr[0*AW +: AW] = 10'h3FF;
        arb_cycle();
        chk("rd_3ff", 32'(rd), 32'h0);

        v = 4'b0100; we = 4'b0100; addr[2*AW +: AW] = 10'h055; wd[2*DW +: DW] = 16'hBEEF;
        arb_cycle();
        v = 4'b0001; we = '0; addr[0*AW +: AW] = 10'h055;
        arb_cycle();
        chk("raw_beef", 32'(rd), 32'hBEEF);

        // All requesters busy: rotation starting from ptr=1.
        for (int c = 0; c < 8; c++) begin
            drive_rand(15);
            v = '1;
            arb_cycle();
        end

        // Only 1 and 3 valid with ptr=2.
        v = 4'b0010; we = '0;
        arb_cycle();
        for (int c = 0; c < 3; c++) begin
            drive_rand(15);
            v = 4'b1010;
            arb_cycle();
            chk("pair_rsp", 32'(rv), (c == 1) ? 32'h2 : 32'h8);
        end

        for (int c = 0; c < 3000; c++) begin
            drive_rand(15);
            if ($urandom_range(0, 7) == 0) v = '0;
            arb_cycle();
        end

        // Reset just after an accept drops the response.
        v = 4'b0001; we = '0; addr[0*AW +: AW] = 10'h055;
        #1;
        chk("flight_ready", 32'(rdy), 32'h1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("flight_rsp", 32'(rv), 32'd0);
        chk("flight_rdy", 32'(rdy), 32'd0);
        v = '0;
        @(negedge clk);
        rst_n = 1'b1;
        init_run(DEPTH, 1'b1);
        v = 4'b0001; we = '0; addr[0*AW +: AW] = 10'h055;
        arb_cycle();

        // No-clear instance grants right after reset release.
        @(negedge clk);
        rst0_n = 1'b1;
        v0 = 4'b0100; we0 = 4'b0100; addr0[2*AW +: AW] = 10'd7; wd0[2*DW +: DW] = 16'h1234;
        #1;
        chk("nc_done", 32'(idone0), 32'd1);
        chk("nc_ready_w", 32'(rdy0), 32'h4);
        chk("nc_en", 32'(ren0), 32'd1);
        chk("nc_we", 32'(rwe0), 32'd1);
        @(posedge clk);
        @(negedge clk);
        chk("nc_rsp_w", 32'(rv0), 32'h4);
        chk("nc_data_w", 32'(rd0), 32'h1234);
        v0 = 4'b0010; we0 = '0; addr0[1*AW +: AW] = 10'd7;
        #1;
        chk("nc_ready_r", 32'(rdy0), 32'h2);
        @(posedge clk);
        @(negedge clk);
        chk("nc_rsp_r", 32'(rv0), 32'h2);
        chk("nc_data_r", 32'(rd0), 32'h1234);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
